// File: rtl/npu_argmax_stage.sv
// Argmax over one frame of signed dot-product results; the winning index and
// value are held until the consumer takes them.
module npu_argmax_stage #(
  parameter  int NUM_CLASSES = 10,
  parameter  int DATA_W      = 16,
  localparam int IDX_W       = ($clog2(NUM_CLASSES) < 1) ? 1 : $clog2(NUM_CLASSES)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic        [IDX_W-1:0]  out_class,
  output logic signed [DATA_W-1:0] out_max,
  output logic                     out_err,
  input  logic                     out_ready
);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t                     r_state;
  logic        [IDX_W-1:0]    r_cnt;
  logic signed [DATA_W-1:0]   r_max;
  logic        [IDX_W-1:0]    r_idx;
  logic        [IDX_W-1:0]    r_outClass;
  logic signed [DATA_W-1:0]   r_outMax;
  logic                       r_outErr;

  logic                       w_accept;
  logic                       w_cntAtEnd;
  logic                       w_frameEnd;
  logic                       w_take;
  logic                       w_lenErr;
  logic signed [DATA_W-1:0]   w_nextMax;
  logic        [IDX_W-1:0]    w_nextIdx;

  assign in_ready  = (r_state == COLLECT);
  assign out_valid = (r_state == HOLD);
  assign out_class = r_outClass;
  assign out_max   = r_outMax;
  assign out_err   = r_outErr;

  // First beat always loads; later beats replace only when strictly greater,
  // so ties keep the lower index.
  assign w_accept   = in_valid && in_ready;
  assign w_cntAtEnd = (r_cnt == LAST_IDX);
  assign w_frameEnd = in_last || w_cntAtEnd;
  assign w_take     = (r_cnt == '0) || (in_data > r_max);
  assign w_nextMax  = w_take ? in_data : r_max;
  assign w_nextIdx  = w_take ? r_cnt : r_idx;
  assign w_lenErr   = in_last ^ w_cntAtEnd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= COLLECT;
      r_cnt      <= '0;
      r_max      <= '0;
      r_idx      <= '0;
      r_outClass <= '0;
      r_outMax   <= '0;
      r_outErr   <= 1'b0;
    end else if (flush) begin
      r_state <= COLLECT;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_accept) begin
            r_max <= w_nextMax;
            r_idx <= w_nextIdx;
            if (w_frameEnd) begin
              r_state    <= HOLD;
              r_cnt      <= '0;
              r_outClass <= w_nextIdx;
              r_outMax   <= w_nextMax;
              r_outErr   <= w_lenErr;
            end else begin
              r_cnt <= r_cnt + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state <= COLLECT;
          end
        end
        default: begin
          r_state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npu_argmax_stage.sv
// Directed bench for npu_argmax_stage with hand-computed expected results.
module tb_npu_argmax_stage;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [15:0] in_data = '0;
  logic               in_last = 1'b0;
  logic               in_ready;
  logic               out_valid;
  logic        [3:0]  out_class;
  logic signed [15:0] out_max;
  logic               out_err;
  logic               out_ready = 1'b0;

  int checkCount = 0;
  int errorCount = 0;
  logic signed [15:0] frameBuf [10];

  npu_argmax_stage #(.NUM_CLASSES(10), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_class(out_class), .out_max(out_max),
    .out_err(out_err), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One beat presented for one clock edge; returns #1 after that edge.
  task automatic applyStimulus(input logic signed [15:0] data, input logic last);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic runFrame(input int n, input int lastAt);
    for (int i = 0; i < n; i++) begin
      applyStimulus(frameBuf[i], (i == lastAt));
    end
  endtask

  task automatic checkResult(input string tag, input logic [3:0] cls, input logic [15:0] mx, input logic err);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_class"}, 32'(out_class), 32'(cls));
    checkOutput({tag, "_max"}, 32'($unsigned(out_max)), 32'(mx));
    checkOutput({tag, "_err"}, 32'(out_err), 32'(err));
  endtask

  task automatic releaseOutput();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #2 reset = 1'b0;
    #2;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_class", 32'(out_class), 32'd0);
    checkOutput("rst_out_max", 32'($unsigned(out_max)), 32'd0);
    checkOutput("rst_out_err", 32'(out_err), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic frame with a tie on 12, consumer always ready.
    out_ready = 1'b1;
    frameBuf = '{16'sd5, -16'sd3, 16'sd12, 16'sd7, 16'sd12, 16'sd0, -16'sd1, 16'sd2, 16'sd3, 16'sd4};
    runFrame(10, 9);
    checkResult("basic", 4'd2, 16'd12, 1'b0);
    checkOutput("basic_hold_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("basic_back_in_ready", 32'(in_ready), 32'd1);
    checkOutput("basic_back_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // All-negative frame, then backpressure with in_valid ignored.
    frameBuf = '{-16'sd8, -16'sd2, -16'sd2, -16'sd9, -16'sd20, -16'sd5, -16'sd3, -16'sd7, -16'sd100, -16'sd4};
    runFrame(10, 9);
    checkResult("neg", 4'd1, 16'hFFFE, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'sd30000;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkResult("stall", 4'd1, 16'hFFFE, 1'b0);
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    releaseOutput();
    checkOutput("stall_release_in_ready", 32'(in_ready), 32'd1);

    // Short frame: in_last on beat 3.
    frameBuf = '{16'sd3, 16'sd9, -16'sd1, 16'sd4, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    runFrame(4, 3);
    checkResult("short", 4'd1, 16'd9, 1'b1);
    releaseOutput();

    // Unmarked frame closes itself on beat 9.
    frameBuf = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd8, 16'sd9, 16'sd10};
    runFrame(9, 99);
    checkOutput("long_pre_valid", 32'(out_valid), 32'd0);
    applyStimulus(frameBuf[9], 1'b0);
    checkResult("long", 4'd9, 16'd10, 1'b1);
    releaseOutput();

    // Full-range signed extremes.
    frameBuf = '{-16'sd32768, -16'sd1, -16'sd1, -16'sd1, -16'sd1, 16'sd32767, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    runFrame(10, 9);
    checkResult("extreme", 4'd5, 16'h7FFF, 1'b0);

    // Flush while holding a result.
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    checkOutput("flush_hold_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_hold_in_ready", 32'(in_ready), 32'd1);

    // Flush on beat 4 of a frame, then a full clean frame.
    frameBuf = '{16'sd100, 16'sd200, 16'sd300, 16'sd400, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    runFrame(4, 99);
    flush = 1'b1;
    applyStimulus(16'sd500, 1'b0);
    flush = 1'b0;
    checkOutput("flush_mid_valid", 32'(out_valid), 32'd0);
    frameBuf = '{16'sd5, -16'sd3, 16'sd12, 16'sd7, 16'sd12, 16'sd0, -16'sd1, 16'sd2, 16'sd3, 16'sd4};
    runFrame(9, 99);
    checkOutput("flush_next_pre_valid", 32'(out_valid), 32'd0);
    applyStimulus(frameBuf[9], 1'b1);
    checkResult("flush_next", 4'd2, 16'd12, 1'b0);
    releaseOutput();

    // Reset low on beat 4, then a flat frame where ties keep index 0.
    frameBuf = '{16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    runFrame(4, 99);
    in_valid = 1'b1;
    in_data  = 16'sd1000;
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_mid_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_max", 32'($unsigned(out_max)), 32'd0);
    checkOutput("rst_mid_class", 32'(out_class), 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    frameBuf = '{16'sd7, 16'sd7, 16'sd7, 16'sd7, 16'sd7, 16'sd7, 16'sd7, 16'sd7, 16'sd7, 16'sd7};
    runFrame(9, 99);
    checkOutput("rst_next_pre_valid", 32'(out_valid), 32'd0);
    applyStimulus(frameBuf[9], 1'b1);
    checkResult("rst_next", 4'd0, 16'd7, 1'b0);
    releaseOutput();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
